// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Time-division sampler wrapped around a 4:1 mux. Drives the mux selects
//   (s1,s0) round-robin over the channels enabled in ch_mask. It holds each
//   select for a dwell of 'dwell' cycles, where 0 counts as 1. At the last
//   cycle of each dwell it captures the mux output y_in. One 4-bit frame is
//   assembled per scan of the enabled channels.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           scan enable (level)
//   ch_mask[3:0] channel enable mask, bit k enables mux input ik
//   dwell        cycles each select is held (0 behaves as 1)
//   y_in         mux output y
//   s0, s1       mux select LSB / MSB
//   sample_valid one-cycle pulse, a channel sample was captured
//   sample_ch    channel index of the last capture
//   sample_bit   value of the last capture
//   frame[3:0]   assembled frame, bit k = last sample of channel k
//   frame_valid  one-cycle pulse, frame complete (coincides with sample_valid)
//   busy         high while scanning (state DWELL)
//
// Output protocol: sample_valid and frame_valid are unconditional one-cycle
// pulses with no back-pressure. sample_ch, sample_bit and frame are valid
// whenever a pulse is high, and they hold their values between pulses.
// With a dwell of 1, sample_valid stays high on consecutive cycles, one
// capture per cycle.
module mux_scan_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic               s0,
  output logic               s1,
  output logic               sample_valid,
  output logic [1:0]         sample_ch,
  output logic               sample_bit,
  output logic [3:0]         frame,
  output logic               frame_valid,
  output logic               busy
);

  typedef enum logic {IDLE = 1'b0, DWELL = 1'b1} state_t;

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t             state, state_d;
  logic [3:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [1:0]         ch, ch_d;
  logic               sample_valid_d, sample_bit_d, frame_valid_d;
  logic [1:0]         sample_ch_d;
  logic [3:0]         frame_d, frame_tmp;
  logic [DWELL_W-1:0] dwell_eff;

  // Lowest set bit of a non-zero mask.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    lowest_bit = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_bit = 2'(i);
    end
  endfunction

  // True if the mask has any set bit above channel c.
  function automatic logic has_above(input logic [3:0] m, input logic [1:0] c);
    has_above = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && (i > int'(c))) has_above = 1'b1;
    end
  endfunction

  // Next set bit above c. It wraps to the lowest set bit.
  function automatic logic [1:0] next_bit(input logic [3:0] m, input logic [1:0] c);
    next_bit = lowest_bit(m);
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) next_bit = 2'(i);
    end
  endfunction

  assign dwell_eff = (dwell == '0) ? DWELL_ONE : dwell;

  // The select register is the channel register. It is forced to 0 whenever
  // the FSM sits in IDLE, so s1/s0 read 00 outside a scan.
  assign s1   = ch[1];
  assign s0   = ch[0];
  assign busy = (state == DWELL);

  always_comb begin
    state_d        = state;
    mask_d         = mask_q;
    dwell_d        = dwell_q;
    cnt_d          = cnt;
    ch_d           = ch;
    sample_valid_d = 1'b0;
    frame_valid_d  = 1'b0;
    sample_ch_d    = sample_ch;
    sample_bit_d   = sample_bit;
    frame_tmp      = frame;
    frame_d        = frame;

    unique case (state)
      IDLE: begin
        if (en && (ch_mask != 4'b0000)) begin
          mask_d  = ch_mask;
          dwell_d = dwell_eff;
          ch_d    = lowest_bit(ch_mask);
          cnt_d   = '0;
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (!en) begin
          // Abort beats capture. The partial frame is dropped and frame
          // keeps its last complete value.
          state_d = IDLE;
          ch_d    = 2'd0;
          cnt_d   = '0;
        end else if (cnt == (dwell_q - DWELL_ONE)) begin
          sample_bit_d   = y_in;
          sample_ch_d    = ch;
          sample_valid_d = 1'b1;
          cnt_d          = '0;
          frame_tmp[ch]  = y_in;
          if (!has_above(mask_q, ch)) begin
            // Frame completion: clear disabled channels, then take the new
            // mask and dwell for the next frame.
            frame_valid_d = 1'b1;
            frame_tmp     = frame_tmp & mask_q;
            mask_d        = ch_mask;
            dwell_d       = dwell_eff;
            if (ch_mask == 4'b0000) begin
              state_d = IDLE;
              ch_d    = 2'd0;
            end else begin
              ch_d = lowest_bit(ch_mask);
            end
          end else begin
            ch_d = next_bit(mask_q, ch);
          end
          frame_d = frame_tmp;
        end else begin
          cnt_d = cnt + DWELL_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mask_q       <= 4'b0000;
      dwell_q      <= DWELL_ONE;
      cnt          <= '0;
      ch           <= 2'd0;
      sample_valid <= 1'b0;
      sample_ch    <= 2'd0;
      sample_bit   <= 1'b0;
      frame        <= 4'b0000;
      frame_valid  <= 1'b0;
    end else begin
      state        <= state_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      cnt          <= cnt_d;
      ch           <= ch_d;
      sample_valid <= sample_valid_d;
      sample_ch    <= sample_ch_d;
      sample_bit   <= sample_bit_d;
      frame        <= frame_d;
      frame_valid  <= frame_valid_d;
    end
  end

endmodule
